// File: rtl/gpu_draw_sequencer.sv
// Primitive sequencer: serial x/y coordinates -> vertex FIFO -> points/lines/triangles/strips -> line-draw requests.
// Optional edge clipping against H_RES x V_RES is compiled in with `define DRAW_SEQ_CLIP_EN.
module gpu_draw_sequencer #(
  parameter int COORD_W    = 10,
  parameter int VBUF_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   prim_count,
  input  logic               coord_valid,
  input  logic [COORD_W-1:0] coord_in,
  output logic               coord_ready,
  output logic               line_start,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  input  logic               line_done,
  output logic               busy,
  output logic               done,
  output logic               reject
);

  localparam int AW = $clog2(VBUF_DEPTH);
  localparam int VW = 2 * COORD_W;
  localparam logic [AW:0]        FIFO_FULL  = (AW+1)'(VBUF_DEPTH);
  localparam logic [AW:0]        FIFO_EMPTY = (AW+1)'(0);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [COORD_W:0]   H_LIM      = (COORD_W+1)'(H_RES);
  localparam logic [COORD_W:0]   V_LIM      = (COORD_W+1)'(V_RES);
  localparam logic [1:0] M_POINTS = 2'd0;
  localparam logic [1:0] M_LINES  = 2'd1;
  localparam logic [1:0] M_TRI    = 2'd2;
  localparam logic [1:0] M_STRIP  = 2'd3;

`ifdef DRAW_SEQ_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         fidx_q, fidx_d;
  logic [1:0]         eidx_q, eidx_d;
  logic [VW-1:0]      v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic               line_start_q, line_start_d;
  logic               busy_q, busy_d, done_q, done_d, reject_q, reject_d;
  logic               clip_q, clip_d;
  logic [COORD_W-1:0] pend_x_q, pend_x_d;
  logic               have_x_q, have_x_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        fcount_q, fcount_d;
  logic               coord_ready_q, coord_ready_d;
  logic [VW-1:0]      mem_q [VBUF_DEPTH];

  logic               accept_s, push_s, pop_s, enter_issue_s, clip_s, final_s, last_edge_s;
  logic [1:0]         need_s, last_eidx_s;
  logic [VW-1:0]      pop_data_s;
  logic [2*VW-1:0]    ep_s;

  // Edge k of the current primitive as {x0,y0,x1,y1}; vertices are packed {x,y}.
  function automatic logic [2*VW-1:0] edge_sel(input logic [1:0] m, input logic [1:0] e,
                                               input logic [VW-1:0] a, input logic [VW-1:0] b,
                                               input logic [VW-1:0] c);
    logic [2*VW-1:0] r;
    r = {a, b};
    case (m)
      M_POINTS: r = {a, a};
      M_TRI: begin
        case (e)
          2'd0:    r = {a, b};
          2'd1:    r = {b, c};
          2'd2:    r = {c, a};
          default: r = {a, b};
        endcase
      end
      default: r = {a, b};
    endcase
    return r;
  endfunction

  // Coordinate intake: x is parked in pend_x, the following y pushes the vertex.
  always_comb begin
    accept_s = coord_valid & coord_ready_q;
    push_s   = accept_s & have_x_q;
    have_x_d = have_x_q;
    pend_x_d = pend_x_q;
    if (accept_s) begin
      have_x_d = ~have_x_q;
      if (!have_x_q) begin
        pend_x_d = coord_in;
      end else begin
        pend_x_d = pend_x_q;
      end
    end else begin
      have_x_d = have_x_q;
    end
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fcount_d = fcount_q + (AW+1)'(1);
      2'b01:   fcount_d = fcount_q - (AW+1)'(1);
      default: fcount_d = fcount_q;
    endcase
    coord_ready_d = (fcount_d != FIFO_FULL);
    pop_data_s    = mem_q[rd_ptr_q];
  end

  // Sequencer FSM next-state, vertex capture and edge issue.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    cnt_d         = cnt_q;
    fidx_d        = fidx_q;
    eidx_d        = eidx_q;
    v0_d          = v0_q;
    v1_d          = v1_q;
    v2_d          = v2_q;
    reject_d      = reject_q;
    done_d        = 1'b0;
    pop_s         = 1'b0;
    enter_issue_s = 1'b0;

    case (mode_q)
      M_POINTS: need_s = 2'd1;
      M_LINES:  need_s = 2'd2;
      M_TRI:    need_s = 2'd3;
      default:  need_s = 2'd2;
    endcase
    last_eidx_s = (mode_q == M_TRI) ? 2'd2 : 2'd0;
    last_edge_s = (eidx_q == last_eidx_s);
    final_s     = (cnt_q == CNT_ONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          cnt_d    = prim_count;
          fidx_d   = 2'd0;
          eidx_d   = 2'd0;
          reject_d = 1'b0;
          if (prim_count != CNT_ZERO) begin
            state_d = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (fcount_q != FIFO_EMPTY) begin
          pop_s = 1'b1;
          case (fidx_q)
            2'd0:    v0_d = pop_data_s;
            2'd1:    v1_d = pop_data_s;
            default: v2_d = pop_data_s;
          endcase
          if (fidx_q == (need_s - 2'd1)) begin
            state_d       = S_ISSUE;
            eidx_d        = 2'd0;
            enter_issue_s = 1'b1;
          end else begin
            fidx_d = fidx_q + 2'd1;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ISSUE: begin
        // A clipped edge skips WAIT and advances as if the rasteriser had finished it.
        if (clip_q) begin
          reject_d = 1'b1;
          if (last_edge_s) begin
            state_d = S_NEXT;
            done_d  = final_s;
          end else begin
            eidx_d        = eidx_q + 2'd1;
            state_d       = S_ISSUE;
            enter_issue_s = 1'b1;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (line_done) begin
          if (last_edge_s) begin
            state_d = S_NEXT;
            done_d  = final_s;
          end else begin
            eidx_d        = eidx_q + 2'd1;
            state_d       = S_ISSUE;
            enter_issue_s = 1'b1;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_NEXT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (!final_s) begin
          state_d = S_FETCH;
          if (mode_q == M_STRIP) begin
            v0_d   = v1_q;
            fidx_d = 2'd1;
          end else begin
            fidx_d = 2'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ep_s   = edge_sel(mode_q, eidx_d, v0_d, v1_d, v2_d);
    clip_s = CLIP_EN && (({1'b0, ep_s[2*VW-1 -: COORD_W]} >= H_LIM) ||
                         ({1'b0, ep_s[VW+COORD_W-1 -: COORD_W]} >= V_LIM) ||
                         ({1'b0, ep_s[VW-1 -: COORD_W]} >= H_LIM) ||
                         ({1'b0, ep_s[COORD_W-1:0]} >= V_LIM));
    if (enter_issue_s) begin
      {x0_d, y0_d, x1_d, y1_d} = ep_s;
      line_start_d = ~clip_s;
      clip_d       = clip_s;
    end else begin
      {x0_d, y0_d, x1_d, y1_d} = {x0_q, y0_q, x1_q, y1_q};
      line_start_d = 1'b0;
      clip_d       = 1'b0;
    end
    // busy already drops in the cycle that carries the done pulse.
    busy_d = (state_d != S_IDLE) && !done_d;
  end

  // Vertex storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {pend_x_q, coord_in};
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mode_q        <= 2'd0;
      cnt_q         <= CNT_ZERO;
      fidx_q        <= 2'd0;
      eidx_q        <= 2'd0;
      v0_q          <= {VW{1'b0}};
      v1_q          <= {VW{1'b0}};
      v2_q          <= {VW{1'b0}};
      x0_q          <= {COORD_W{1'b0}};
      y0_q          <= {COORD_W{1'b0}};
      x1_q          <= {COORD_W{1'b0}};
      y1_q          <= {COORD_W{1'b0}};
      line_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      reject_q      <= 1'b0;
      clip_q        <= 1'b0;
      pend_x_q      <= {COORD_W{1'b0}};
      have_x_q      <= 1'b0;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      fcount_q      <= FIFO_EMPTY;
      coord_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      fidx_q        <= fidx_d;
      eidx_q        <= eidx_d;
      v0_q          <= v0_d;
      v1_q          <= v1_d;
      v2_q          <= v2_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      line_start_q  <= line_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      reject_q      <= reject_d;
      clip_q        <= clip_d;
      pend_x_q      <= pend_x_d;
      have_x_q      <= have_x_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fcount_q      <= fcount_d;
      coord_ready_q <= coord_ready_d;
    end
  end

  assign coord_ready = coord_ready_q;
  assign line_start  = line_start_q;
  assign x0          = x0_q;
  assign y0          = y0_q;
  assign x1          = x1_q;
  assign y1          = y1_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign reject      = reject_q;

endmodule

// File: tb/tb_gpu_draw_sequencer.sv
// Directed bench for gpu_draw_sequencer: a cycle table for reset/zero-count/FIFO-full behaviour,
// then hand-written command sequences with a rasteriser model answering line_start.
module tb_gpu_draw_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] prim_count = 8'd0;
  logic       coord_valid = 1'b0;
  logic [9:0] coord_in = 10'd0;
  logic       coord_ready, line_start, busy, done, reject;
  logic [9:0] x0, y0, x1, y1;
  logic       tbl_ld = 1'b0;
  logic       resp_ld = 1'b0;
  logic       resp_en = 1'b0;
  logic       line_done;

  assign line_done = tbl_ld | resp_ld;

  gpu_draw_sequencer #(.COORD_W(10), .VBUF_DEPTH(8), .CNT_W(8), .H_RES(640), .V_RES(480)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .prim_count(prim_count),
    .coord_valid(coord_valid), .coord_in(coord_in), .coord_ready(coord_ready),
    .line_start(line_start), .x0(x0), .y0(y0), .x1(x1), .y1(y1), .line_done(line_done),
    .busy(busy), .done(done), .reject(reject)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic [1:0] md;
    logic [7:0] pc;
    logic       vld;
    logic [9:0] crd;
    logic       ld;
    logic       e_rdy, e_busy, e_done, e_ls;
    logic [9:0] e_x0, e_y0, e_x1, e_y1;
  } vec_t;

  typedef struct {
    logic [9:0] x0, y0, x1, y1;
    int         c;
  } ev_t;

  vec_t tv [29];
  ev_t  evq [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   done_busy_bad = 0;
  int   c0, d0, nls;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Observer: records every draw request and every done pulse.
  initial forever begin
    ev_t e;
    @(negedge clock);
    if (line_start) begin
      e.x0 = x0; e.y0 = y0; e.x1 = x1; e.y1 = y1; e.c = cyc;
      evq.push_back(e);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) done_busy_bad++;
    end
  end

  // Rasteriser model: line_done five cycles after each line_start.
  initial forever begin
    @(posedge clock); #1;
    while (resp_en && line_start) begin
      repeat (5) @(posedge clock);
      #1 resp_ld = 1'b1;
      @(posedge clock);
      #1 resp_ld = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [9:0] w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      coord_valid = 1'b1;
      coord_in = w;
      if (coord_ready) begin
        ok = 1'b1;
        tick;
        break;
      end
      tick;
    end
    coord_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL push timeout: word %0d not accepted, expected acceptance", w);
    end
  endtask

  task automatic push_vtx(input logic [9:0] x, input logic [9:0] y);
    push_word(x);
    push_word(y);
  endtask

  task automatic start_cmd(input logic [1:0] m, input logic [7:0] n, output int cs);
    cs = cyc;
    start = 1'b1; mode = m; prim_count = n;
    tick;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int  dstart;
    bit  got;
    dstart = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (done_cnt != dstart) begin
        got = 1'b1;
        break;
      end
    end
    chk("done within budget", 32'(got), 32'd1);
  endtask

  task automatic chk_edge(input int i, input int ex0, input int ey0, input int ex1, input int ey1,
                          input string nm);
    if (i >= evq.size()) begin
      total++; bad++;
      $display("FAIL %s: edge %0d missing, expected (%0d,%0d)-(%0d,%0d)", nm, i, ex0, ey0, ex1, ey1);
    end else begin
      chk({nm, " x0"}, 32'(evq[i].x0), 32'(ex0));
      chk({nm, " y0"}, 32'(evq[i].y0), 32'(ey0));
      chk({nm, " x1"}, 32'(evq[i].x1), 32'(ex1));
      chk({nm, " y1"}, 32'(evq[i].y1), 32'(ey1));
    end
  endtask

  initial begin
    // Rows: 0-3 zero-count command + spurious line_done; 4-19 fill 8 vertices; 20-22 offers while full;
    // 23-28 one-point command that frees a slot.
    for (int i = 0; i < 29; i++) begin
      tv[i] = '{default: '0};
      tv[i].e_rdy = 1'b1;
    end
    tv[0].st = 1'b1;
    tv[1].e_done = 1'b1;
    tv[1].ld = 1'b1;
    for (int i = 4; i < 20; i++) begin
      tv[i].vld = 1'b1;
      tv[i].crd = 10'(i - 3);
    end
    for (int i = 20; i < 23; i++) begin
      tv[i].vld = 1'b1;
      tv[i].crd = 10'd999;
      tv[i].e_rdy = 1'b0;
    end
    tv[23].st = 1'b1; tv[23].pc = 8'd1; tv[23].e_rdy = 1'b0;
    tv[24].e_rdy = 1'b0; tv[24].e_busy = 1'b1;
    tv[25].e_busy = 1'b1; tv[25].e_ls = 1'b1;
    tv[26].e_busy = 1'b1; tv[26].ld = 1'b1;
    tv[27].e_done = 1'b1;
    for (int i = 25; i < 29; i++) begin
      tv[i].e_x0 = 10'd1; tv[i].e_y0 = 10'd2; tv[i].e_x1 = 10'd1; tv[i].e_y1 = 10'd2;
    end

    repeat (3) tick;
    reset = 1'b0;
    for (int i = 0; i < 29; i++) begin
      chk($sformatf("row%0d coord_ready", i), 32'(coord_ready), 32'(tv[i].e_rdy));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("row%0d done", i), 32'(done), 32'(tv[i].e_done));
      chk($sformatf("row%0d line_start", i), 32'(line_start), 32'(tv[i].e_ls));
      chk($sformatf("row%0d x0", i), 32'(x0), 32'(tv[i].e_x0));
      chk($sformatf("row%0d y0", i), 32'(y0), 32'(tv[i].e_y0));
      chk($sformatf("row%0d x1", i), 32'(x1), 32'(tv[i].e_x1));
      chk($sformatf("row%0d y1", i), 32'(y1), 32'(tv[i].e_y1));
      chk($sformatf("row%0d reject", i), 32'(reject), 32'd0);
      start = tv[i].st; mode = tv[i].md; prim_count = tv[i].pc;
      coord_valid = tv[i].vld; coord_in = tv[i].crd; tbl_ld = tv[i].ld;
      tick;
    end
    start = 1'b0; coord_valid = 1'b0; tbl_ld = 1'b0;

    // Drain the seven remaining vertices plus one fresh one; the words offered while full must be absent.
    push_vtx(10'd100, 10'd200);
    evq.delete();
    resp_en = 1'b1;
    start_cmd(2'd0, 8'd8, c0);
    run_until_done(400);
    chk("drain edge count", 32'(evq.size()), 32'd8);
    for (int j = 0; j < 7; j++) begin
      chk_edge(j, 2*j + 3, 2*j + 4, 2*j + 3, 2*j + 4, $sformatf("drain%0d", j));
    end
    chk_edge(7, 100, 200, 100, 200, "drain7");

    // Wireframe triangle with cycle-exact request/done timing.
    push_vtx(10'd10, 10'd20);
    push_vtx(10'd100, 10'd20);
    push_vtx(10'd50, 10'd90);
    evq.delete();
    d0 = done_cnt;
    start_cmd(2'd2, 8'd1, c0);
    run_until_done(200);
    chk("tri edge count", 32'(evq.size()), 32'd3);
    chk_edge(0, 10, 20, 100, 20, "tri e0");
    chk_edge(1, 100, 20, 50, 90, "tri e1");
    chk_edge(2, 50, 90, 10, 20, "tri e2");
    if (evq.size() == 3) begin
      chk("tri e0 cycle", 32'(evq[0].c - c0), 32'd4);
      chk("tri e1 cycle", 32'(evq[1].c - c0), 32'd10);
      chk("tri e2 cycle", 32'(evq[2].c - c0), 32'd16);
    end
    chk("tri done cycle", 32'(done_cyc - c0), 32'd22);
    chk("tri done count", 32'(done_cnt - d0), 32'd1);

    // Line strip of three segments, then one point proving exactly four vertices were consumed.
    push_vtx(10'd1, 10'd1);
    push_vtx(10'd2, 10'd2);
    push_vtx(10'd3, 10'd3);
    push_vtx(10'd4, 10'd4);
    push_vtx(10'd9, 10'd9);
    evq.delete();
    start_cmd(2'd3, 8'd3, c0);
    run_until_done(200);
    chk("strip edge count", 32'(evq.size()), 32'd3);
    chk_edge(0, 1, 1, 2, 2, "strip AB");
    chk_edge(1, 2, 2, 3, 3, "strip BC");
    chk_edge(2, 3, 3, 4, 4, "strip CD");
    evq.delete();
    start_cmd(2'd0, 8'd1, c0);
    run_until_done(100);
    chk_edge(0, 9, 9, 9, 9, "strip leftover");

    // Edge with x beyond the screen.
    push_vtx(10'd700, 10'd10);
    push_vtx(10'd5, 10'd5);
    evq.delete();
    start_cmd(2'd1, 8'd1, c0);
    run_until_done(100);
`ifdef DRAW_SEQ_CLIP_EN
    chk("clip no request", 32'(evq.size()), 32'd0);
    chk("clip reject set", 32'(reject), 32'd1);
`else
    chk("noclip edge count", 32'(evq.size()), 32'd1);
    chk_edge(0, 700, 10, 5, 5, "noclip edge");
    chk("noclip reject", 32'(reject), 32'd0);
`endif
    repeat (2) tick;
    start_cmd(2'd0, 8'd0, c0);
    chk("reject after new start", 32'(reject), 32'd0);
    chk("zero-count done", 32'(done), 32'd1);

    // Reset while waiting on the second triangle edge, with one extra vertex buffered.
    repeat (3) tick;
    push_vtx(10'd10, 10'd20);
    push_vtx(10'd100, 10'd20);
    push_vtx(10'd50, 10'd90);
    push_vtx(10'd33, 10'd44);
    evq.delete();
    start_cmd(2'd2, 8'd1, c0);
    nls = 0;
    for (int i = 0; i < 100; i++) begin
      if (line_start) nls++;
      if (nls == 2) break;
      tick;
    end
    chk("second edge reached", 32'(nls), 32'd2);
    tick;
    chk("in WAIT busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("post-reset coord_ready", 32'(coord_ready), 32'd1);
    chk("post-reset line_start", 32'(line_start), 32'd0);
    chk("post-reset endpoints", 32'({x0, y0, x1, y1} != 40'd0), 32'd0);
    chk("post-reset busy", 32'(busy), 32'd0);
    chk("post-reset done", 32'(done), 32'd0);
    chk("post-reset reject", 32'(reject), 32'd0);
    resp_en = 1'b0;
    repeat (12) tick;
    chk("no done after reset", 32'(done_cnt - d0), 32'd0);
    chk("no extra edges after reset", 32'(evq.size()), 32'd2);

    // Flushed FIFO: a point command must stall until a new vertex arrives.
    evq.delete();
    resp_en = 1'b1;
    start_cmd(2'd0, 8'd1, c0);
    repeat (15) tick;
    chk("stall on empty FIFO", 32'(evq.size()), 32'd0);
    chk("stall busy", 32'(busy), 32'd1);
    push_vtx(10'd7, 10'd8);
    run_until_done(100);
    chk("post-flush edge count", 32'(evq.size()), 32'd1);
    chk_edge(0, 7, 8, 7, 8, "post-flush point");
    chk("busy low in done cycle", 32'(done_busy_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_draw_sequencer.md
# gpu_draw_sequencer

Parametrised primitive sequencer between the vertex processor output and the line rasteriser. It collects a serial coordinate stream (x then y per vertex) into a vertex FIFO and assembles points, lines, wireframe triangles or line strips. It issues one line-draw request per edge over a start/done handshake and reports completion of a multi-primitive command. It generalises the fixed three-vertex serial-to-parallel conversion and triangle assembly to configurable width, buffer depth, mode and primitive count.

## Interface
- COORD_W, 10, coordinate width in bits
- VBUF_DEPTH, 8, vertex FIFO depth in vertices; power of two, at least 4
- CNT_W, 8, width of the primitive count
- H_RES, 640 and V_RES, 480, screen bounds used only when clipping is compiled in
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command pulse; ignored while busy=1
- mode  in  2  command mode: 0 points, 1 lines, 2 triangles, 3 line strip; sampled with start
- prim_count  in  CNT_W  number of primitives (strip: number of segments); sampled with start
- coord_valid  in  1  coordinate word valid
- coord_in  in  COORD_W  coordinate word: x first, then y
- coord_ready  out  1  FIFO can accept a word
- line_start  out  1  one-cycle draw request
- x0, y0, x1, y1  out  COORD_W each  edge endpoints; stable from line_start until line_done
- line_done  in  1  rasteriser completion pulse
- busy  out  1  command in progress
- done  out  1  one-cycle command-complete pulse
- reject  out  1  sticky flag: at least one edge was clipped; cleared on an accepted start

## Operation
- Word intake: a word is accepted when coord_valid and coord_ready are both 1. An x word is held in a pending register. The following y word pushes the pair {x,y} into the FIFO.
- coord_ready = !(fifo_count == VBUF_DEPTH). A push and a pop in the same cycle leave the count unchanged.
- FIFO contents persist across commands. Only reset flushes the FIFO and the pending x.
- FSM states: IDLE, FETCH, ISSUE, WAIT, NEXT.
  - IDLE to FETCH on start when prim_count != 0. If prim_count == 0, done pulses the next cycle and the FSM stays in IDLE.
  - FETCH pops one vertex per cycle while the FIFO is non-empty and stalls while it is empty. Vertices needed per primitive: points 1, lines 2, triangles 3. Line strip needs 2 for the first segment and 1 afterwards; for later segments v0 takes the previous v1.
  - ISSUE drives the endpoints of edge k and pulses line_start for one cycle, then moves to WAIT.
  - Edge lists: points (v0,v0); lines (v0,v1); triangles (v0,v1), (v1,v2), (v2,v0); strip (v0,v1).
  - WAIT moves to ISSUE for the next edge on line_done. After the last edge it moves to NEXT.
  - NEXT decrements the remaining count. If the remaining count is nonzero it moves to FETCH; otherwise it pulses done and returns to IDLE.
- line_done is ignored outside WAIT.
- start is ignored outside IDLE.
- Reset mid-command: the FSM returns to IDLE, the FIFO is flushed, and no done pulse is generated.

## Timing
- Reset values: coord_ready 1, line_start 0, x0/y0/x1/y1 0, busy 0, done 0, reject 0.
- busy = 1 from the cycle after the accepted start until the cycle done pulses; it is 0 in the done cycle.
- With enough vertices already buffered, start at cycle 0 gives FETCH pops at cycles 1..n (n vertices needed) and line_start at cycle n+1.
- A line_done in cycle t gives the next line_start at t+1.
- For the final edge, line_done at t gives NEXT at t+1. done pulses at t+1 when the count reaches 0; otherwise FETCH starts at t+2.
- Endpoint outputs are registered and change only on entry to ISSUE.

## Configuration
- DRAW_SEQ_CLIP_EN defined:
  - In ISSUE, an edge with any endpoint x >= H_RES or y >= V_RES is not issued. There is no line_start and no WAIT; the FSM advances as if line_done had occurred in the same cycle.
  - reject is set when an edge is skipped this way.
- DRAW_SEQ_CLIP_EN undefined: every edge is issued and reject is tied to 0.

## Test plan
- Triangles, prim_count=1; stream (10,20),(100,20),(50,90); line_done 5 cycles after each line_start. Required: three line_start pulses with endpoints (10,20)-(100,20), (100,20)-(50,90), (50,90)-(10,20); done pulses once; busy drops in the done cycle.
- Line strip, prim_count=3; vertices A,B,C,D. Required: edges A-B, B-C, C-D; exactly 4 FIFO pops.
- FIFO full: push 2·VBUF_DEPTH words with no command active. Required: coord_ready=0 after VBUF_DEPTH vertices; words offered while full are not accepted; ready returns to 1 the cycle after a pop.
- start with prim_count=0. Required: done at cycle 1 and no line_start. A spurious line_done in IDLE has no effect.
- Reset asserted during WAIT of the second triangle edge. Required: all outputs at reset values the next cycle, FIFO empty, no done pulse.
- With DRAW_SEQ_CLIP_EN defined, lines mode, vertices (700,10),(5,5). Required: no line_start, reject=1, done pulses. The same stimulus without the macro issues the edge.
